// File: rtl/outbuff_writer.sv
// Output-buffer writer: moves engine parity words into the output buffer
// through a 2-entry skid FIFO, sequencing rows/stripes and flagging errors.
module outbuff_writer #(
  parameter int M_MIN         = 2,
  parameter int M_MAX         = 128,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int WORD_W        = W * PACKET_LENGTH,
  parameter int OUT_DEPTH     = 256,
  parameter int ADDR_W        = $clog2(OUT_DEPTH),
  parameter int M_W           = $clog2(M_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cntrl_outbuff_wr_en,
  input  logic [M_W-1:0]    m_cfg,
  input  logic              eng_res_valid,
  input  logic [WORD_W-1:0] eng_res_data,
  output logic              eng_res_ready,
  input  logic              outbuff_full,
  output logic              outbuff_wr,
  output logic [ADDR_W-1:0] outbuff_addr,
  output logic [WORD_W-1:0] outbuff_wdata,
  output logic              stripe_done,
  output logic [15:0]       stripe_cnt,
  output logic              wr_idle,
  output logic              partial_err,
  output logic              drop_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t              state, state_nx;
  logic [WORD_W-1:0]   fifo_mem [2];
  logic                wp, rp;
  logic [1:0]          cnt;
  logic [ADDR_W-1:0]   addr;
  logic [M_W-1:0]      row, m_lat, m_clamp;
  logic                push, pop, start, finish, last_row;

  // Stripe length is bounded so row sequencing never sees 0 or 1 rows.
  assign m_clamp  = (m_cfg < M_W'(M_MIN)) ? M_W'(M_MIN) :
                    (m_cfg > M_W'(M_MAX)) ? M_W'(M_MAX) : m_cfg;
  assign last_row = (row == m_lat - M_W'(1));

  assign outbuff_addr  = addr;
  assign outbuff_wdata = fifo_mem[rp];
  assign wr_idle       = (state == IDLE) && (cnt == 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state plus handshake strobes; ready uses the registered count only.
  always_comb begin
    state_nx      = state;
    start         = 1'b0;
    finish        = 1'b0;
    eng_res_ready = (state == ACTIVE) && (cnt != 2'd2);
    outbuff_wr    = (state != IDLE) && (cnt != 2'd0) && !outbuff_full;
    case (state)
      IDLE: if (cntrl_outbuff_wr_en) begin
        state_nx = ACTIVE;
        start    = 1'b1;
      end
      ACTIVE: if (!cntrl_outbuff_wr_en) state_nx = DRAIN;
      DRAIN: begin
        if (cntrl_outbuff_wr_en) state_nx = ACTIVE;
        else if (cnt == 2'd0) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    push = eng_res_valid && eng_res_ready;
    pop  = outbuff_wr;
  end

  // FIFO payload storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= eng_res_data;
  end

  // FIFO pointers, address/row/stripe sequencing and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp          <= 1'b0;
      rp          <= 1'b0;
      cnt         <= 2'd0;
      addr        <= '0;
      row         <= '0;
      m_lat       <= M_W'(M_MIN);
      stripe_done <= 1'b0;
      stripe_cnt  <= 16'd0;
      partial_err <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      stripe_done <= 1'b0;
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (pop) begin
        addr <= addr + ADDR_W'(1);
        if (last_row) begin
          row         <= '0;
          stripe_done <= 1'b1;
          stripe_cnt  <= stripe_cnt + 16'd1;
        end else begin
          row <= row + M_W'(1);
        end
      end
      if (state == IDLE && eng_res_valid) drop_err <= 1'b1;
      if (finish && row != '0) partial_err <= 1'b1;
      // A new session starts from a clean slate; no write can coincide.
      if (start) begin
        addr        <= '0;
        row         <= '0;
        stripe_cnt  <= 16'd0;
        m_lat       <= m_clamp;
        partial_err <= 1'b0;
        drop_err    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/outbuff_writer.md
Name: outbuff_writer

Overview:
- Output-buffer side of the engine datapath: takes parity words from the encoding engine and writes them into the output buffer memory.
- Sequences rows and stripes, and absorbs output-buffer backpressure through a 2-entry skid FIFO.
- Enabled by the control FSM's cntrl_outbuff_wr_en. Raises status and error flags for the control registers.

Parameters:
- M_MIN, 2, minimum parity rows per stripe.
- M_MAX, 128, maximum parity rows per stripe.
- W, 4, Galois-field word width in bits.
- PACKET_LENGTH, 2, words per packet.
- WORD_W, W*PACKET_LENGTH, engine result/output buffer data width.
- OUT_DEPTH, 256, output buffer entries (power of two).
- ADDR_W, $clog2(OUT_DEPTH), output buffer address width.
- M_W, $clog2(M_MAX+1), width of m_cfg.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cntrl_outbuff_wr_en  in  1  write enable from control FSM
- m_cfg  in  M_W  parity rows per stripe (from MReg)
- eng_res_valid  in  1  engine result word valid
- eng_res_data  in  WORD_W  engine result word
- eng_res_ready  out  1  writer can accept a word
- outbuff_full  in  1  output buffer cannot accept a write this cycle
- outbuff_wr  out  1  output buffer write strobe
- outbuff_addr  out  ADDR_W  write address
- outbuff_wdata  out  WORD_W  write data
- stripe_done  out  1  one-cycle pulse per completed stripe
- stripe_cnt  out  16  stripes completed this session
- wr_idle  out  1  writer in IDLE with FIFO empty
- partial_err  out  1  sticky: session ended mid-stripe
- drop_err  out  1  sticky: eng_res_valid seen in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high (rst). All state clears on rst.
  - state=IDLE, FIFO empty, addr=0, row=0, m_lat=M_MIN.
  - Outputs: outbuff_wr=0, eng_res_ready=0, stripe_done=0, stripe_cnt=0, wr_idle=1, partial_err=0, drop_err=0.
  - rst mid-session discards FIFO contents with no write.
- FSM states: IDLE, ACTIVE, DRAIN.
- IDLE -> ACTIVE when cntrl_outbuff_wr_en=1. On entry:
  - addr, row and stripe_cnt cleared.
  - m_lat latched as m_cfg clamped to [M_MIN, M_MAX].
  - partial_err and drop_err cleared.
- ACTIVE -> DRAIN when cntrl_outbuff_wr_en=0.
- DRAIN -> ACTIVE when cntrl_outbuff_wr_en=1. addr, row, stripe_cnt and m_lat are kept.
- DRAIN -> IDLE when the FIFO is empty and cntrl_outbuff_wr_en=0. If row!=0 at that point, partial_err sets.
- eng_res_ready:
  - =1 only in ACTIVE with registered FIFO count<2.
  - =0 in IDLE and DRAIN.
  - An accept is eng_res_valid & eng_res_ready. It pushes eng_res_data into the FIFO.
- eng_res_valid=1 in IDLE sets drop_err. The word is discarded.
- outbuff_wr is combinational: (state!=IDLE) & FIFO non-empty & ~outbuff_full.
  - outbuff_wdata = FIFO head; outbuff_addr = addr register.
  - A write pops the FIFO head.
- Latency: a word accepted in cycle t with an empty FIFO and outbuff_full=0 appears on outbuff_wr in cycle t+1.
  - Sustained throughput is 1 word/cycle.
- Push and pop in the same cycle are legal. Count is unchanged and order is preserved (FIFO order).
- On each write, addr increments and wraps from OUT_DEPTH-1 to 0.
- Row and stripe sequencing on each write:
  - row increments.
  - On the write with row==m_lat-1: row resets to 0, and in the next cycle stripe_done pulses high for one cycle with stripe_cnt+1.
  - stripe_cnt wraps at 2^16.
- outbuff_full=1 holds the FIFO. With count=2, eng_res_ready drops the following cycle, so no word is lost or duplicated.
- wr_idle = (state==IDLE) & FIFO empty.

Test Plan:
- Basic stripe: rst, m_cfg=3, wr_en=1, 6 back-to-back words D0..D5 -> writes at addr 0..5, one per cycle starting one cycle after the first accept; stripe_done pulses after the addr 2 and addr 5 writes; stripe_cnt=2.
- Backpressure: outbuff_full=1 for 4 cycles mid-stream with continuous valid -> eng_res_ready low after 2 buffered words; no writes while full; data order and addresses contiguous after release; no loss.
- Wrap: OUT_DEPTH=256, 258 words with m_cfg=2 -> 256th write at addr 255, next at addr 0, then 1; stripe_cnt=129.
- Drain/partial: m_cfg=4, 2 words accepted, then wr_en=0 -> both words written, state returns to IDLE, partial_err=1; a new wr_en=1 session clears it.
- Resume and clamp: wr_en dropped and reasserted during DRAIN -> addr and row continue, no clear; m_cfg=0 -> m_lat=2; m_cfg=200 -> m_lat=128.
- Idle drop and reset: valid=1 in IDLE -> drop_err=1 and no write; rst with 2 words in FIFO -> outbuff_wr=0 the next cycle and all outputs at reset values.
